// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative RV32M multiply/divide unit.
//   XLEN_DEFAULT : default operand/result width
//   funct3_e     : RV32M op encodings carried on funct3
//   state_e      : FSM state encoding, also exported on the debug port
package muldiv_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_CALC   = 2'b01,
    ST_FINISH = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: combinational sign handling around the unsigned core.
// Front half (live operands, used on the accepting edge):
//   funct3_i, op_a_i, op_b_i -> a_mag_o, b_mag_o (magnitudes),
//   neg_res_o (negate product/quotient), neg_rem_o (negate remainder)
// Back half (registered values, used on the edge entering FINISH):
//   neg_res_i, neg_rem_i, prod_i, quo_i, rem_i -> prod_o, quo_o, rem_o
//   (two's-complement corrected results)
module muldiv_sign_fix
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [2:0]        funct3_i,
  input  logic [XLEN-1:0]   op_a_i,
  input  logic [XLEN-1:0]   op_b_i,
  output logic [XLEN-1:0]   a_mag_o,
  output logic [XLEN-1:0]   b_mag_o,
  output logic              neg_res_o,
  output logic              neg_rem_o,
  input  logic              neg_res_i,
  input  logic              neg_rem_i,
  input  logic [2*XLEN-1:0] prod_i,
  input  logic [XLEN-1:0]   quo_i,
  input  logic [XLEN-1:0]   rem_i,
  output logic [2*XLEN-1:0] prod_o,
  output logic [XLEN-1:0]   quo_o,
  output logic [XLEN-1:0]   rem_o
);

  logic a_signed, b_signed, a_neg, b_neg;

  // MUL is treated as unsigned: its low half is sign-agnostic anyway.
  assign a_signed = (funct3_i == F3_MULH) || (funct3_i == F3_MULHSU) ||
                    (funct3_i == F3_DIV)  || (funct3_i == F3_REM);
  assign b_signed = (funct3_i == F3_MULH) || (funct3_i == F3_DIV) ||
                    (funct3_i == F3_REM);

  assign a_neg = a_signed & op_a_i[XLEN-1];
  assign b_neg = b_signed & op_b_i[XLEN-1];

  // Negating the most negative value wraps to itself, which is the correct
  // unsigned magnitude 2^(XLEN-1).
  assign a_mag_o   = a_neg ? -op_a_i : op_a_i;
  assign b_mag_o   = b_neg ? -op_b_i : op_b_i;
  assign neg_res_o = a_neg ^ b_neg;
  // Remainder follows the dividend; only REM has a signed dividend.
  assign neg_rem_o = a_neg & (funct3_i == F3_REM);

  assign prod_o = neg_res_i ? -prod_i : prod_i;
  assign quo_o  = neg_res_i ? -quo_i  : quo_i;
  assign rem_o  = neg_rem_i ? -rem_i  : rem_i;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, one bit per cycle.
// Ports:
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   start_i, funct3_i  : start request and op select (sampled in IDLE only)
//   op_a_i, op_b_i     : rs1 / rs2, captured on the accepting edge
//   flush_i            : abort; wins over start and over a finishing op
//   busy_o             : high whenever state != IDLE (pipeline stall)
//   done_o             : one-cycle pulse, result_o valid while high
//   result_o           : registered result, changes only on entry to FINISH
//   state_o            : FSM state for debug/checkers
// Handshake: a request is accepted on a rising edge where start_i=1,
// flush_i=0 and busy_o=0; start_i is ignored while busy_o=1 (no queueing).
// Each accepted, unflushed request yields exactly one done_o pulse.
// XLEN must be even and within 8..64.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output state_e          state_o
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN);
  localparam logic [XLEN-1:0] SMIN     = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q;
  logic            busy_q, done_q;
  logic [XLEN-1:0] result_q;
  logic [2:0]      op_q;
  logic [CW-1:0]   cnt_q;
  // acc_q: product high half / partial remainder.
  // lo_q : multiplier shifting out, product low half / dividend->quotient.
  // opnd_q: multiplicand magnitude or divisor magnitude.
  logic [XLEN-1:0] acc_q, lo_q, opnd_q;
  logic            neg_res_q, neg_rem_q;

  logic [XLEN-1:0]   a_mag, b_mag;
  logic              neg_res, neg_rem;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .funct3_i  (funct3_i),
    .op_a_i    (op_a_i),
    .op_b_i    (op_b_i),
    .a_mag_o   (a_mag),
    .b_mag_o   (b_mag),
    .neg_res_o (neg_res),
    .neg_rem_o (neg_rem),
    .neg_res_i (neg_res_q),
    .neg_rem_i (neg_rem_q),
    .prod_i    ({acc_q, lo_q}),
    .quo_i     (lo_q),
    .rem_i     (acc_q),
    .prod_o    (prod_fix),
    .quo_o     (quo_fix),
    .rem_o     (rem_fix)
  );

  // Special cases resolved on the accepting edge, bypassing CALC.
  logic            is_div, div_zero, div_ovf, special;
  logic [XLEN-1:0] fast_res;

  assign is_div   = funct3_i[2];
  assign div_zero = is_div && (op_b_i == '0);
  assign div_ovf  = ((funct3_i == F3_DIV) || (funct3_i == F3_REM)) &&
                    (op_a_i == SMIN) && (&op_b_i);
  assign special  = div_zero || div_ovf;

  // funct3[1] separates REM/REMU (1) from DIV/DIVU (0).
  always_comb begin
    fast_res = '0;
    if (div_zero) fast_res = funct3_i[1] ? op_a_i : '1;
    else if (div_ovf) fast_res = funct3_i[1] ? '0 : op_a_i;
  end

  // One iteration step of the shared datapath.
  logic [XLEN:0]   sum, shl;
  logic [XLEN-1:0] diff, acc_step, lo_step;
  logic            ge;

  always_comb begin
    sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    shl  = {acc_q, lo_q[XLEN-1]};
    ge   = (shl >= {1'b0, opnd_q});
    // When ge holds the true difference is below opnd_q, so XLEN bits suffice.
    diff = shl[XLEN-1:0] - opnd_q;
    if (op_q[2]) begin
      // Restoring divide: keep the trial subtraction only if it did not borrow.
      acc_step = ge ? diff : shl[XLEN-1:0];
      lo_step  = {lo_q[XLEN-2:0], ge};
    end else begin
      // Shift-add multiply: add multiplicand if the multiplier LSB is set,
      // then shift the whole {acc, lo} pair right by one.
      acc_step = sum[XLEN:1];
      lo_step  = {sum[0], lo_q[XLEN-1:1]};
    end
  end

  logic [XLEN-1:0] final_res;

  always_comb begin
    case (op_q)
      F3_MUL:                       final_res = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              final_res = quo_fix;
      default:                      final_res = rem_fix;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      op_q      <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i && !flush_i) begin
            op_q      <= funct3_i;
            cnt_q     <= '0;
            neg_res_q <= neg_res;
            neg_rem_q <= neg_rem;
            acc_q     <= '0;
            busy_q    <= 1'b1;
            if (is_div) begin
              lo_q   <= a_mag;
              opnd_q <= b_mag;
            end else begin
              lo_q   <= b_mag;
              opnd_q <= a_mag;
            end
            if (special) begin
              result_q <= fast_res;
              done_q   <= 1'b1;
              state_q  <= ST_FINISH;
            end else begin
              state_q  <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (flush_i) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            result_q <= final_res;
            done_q   <= 1'b1;
            state_q  <= ST_FINISH;
          end else begin
            acc_q <= acc_step;
            lo_q  <= lo_step;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam logic [31:0] MIN  = 32'h8000_0000;
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [2:0]  funct3_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic        flush_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;
  state_e      state_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] hold;

  muldiv_unit #(.XLEN(32)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (start_i),
    .funct3_i (funct3_i),
    .op_a_i   (op_a_i),
    .op_b_i   (op_b_i),
    .flush_i  (flush_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o),
    .state_o  (state_o)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    logic [31:0] r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    p  = '0;
    r  = '0;
    case (f)
      3'd0: begin p = ua * ub; r = p[31:0];  end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = ONES;
        else if (a == MIN && b == ONES) r = a;
        else begin p = sa / sb; r = p[31:0]; end
      end
      3'd5: r = (b == 0) ? ONES : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == MIN && b == ONES) r = 32'h0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      hold = '0;
    end else if (done_o) begin
      if (exp_q.size() == 0) chk("done_without_request", done_o, 1'b0);
      else begin
        hold = exp_q.pop_front();
        chk("result_at_done", result_o, hold);
      end
    end else begin
      chk("result_hold", result_o, hold);
    end
  end

  // ---------------- driver ----------------
  // Called between edges; the next rising edge accepts the request.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input bit has_lit, input logic [31:0] lit);
    int cyc;
    int exp_lat;
    bit special;
    special = f[2] && ((b == 0) || (!f[0] && a == MIN && b == ONES));
    exp_lat = special ? 0 : 33;
    exp_q.push_back(model(f, a, b));
    funct3_i = f; op_a_i = a; op_b_i = b; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    cyc = 0;
    while (!done_o && cyc < 40) begin
      chk("busy_during_op", busy_o, 1'b1);
      // Noise on the request inputs must neither restart nor alter the op.
      start_i  = 1'($urandom_range(0, 1));
      funct3_i = 3'($urandom_range(0, 7));
      op_a_i   = $urandom;
      op_b_i   = $urandom;
      @(posedge clk); #1;
      cyc++;
    end
    start_i = 1'b0;
    chk("done_latency", cyc, exp_lat);
    chk("busy_at_done", busy_o, 1'b1);
    if (has_lit) chk("directed_result", result_o, lit);
    @(posedge clk); #1;
    chk("idle_after_done", busy_o, 1'b0);
    chk("done_one_cycle", done_o, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;
    rst_n = 1'b0; start_i = 1'b0; flush_i = 1'b0;
    funct3_i = '0; op_a_i = '0; op_b_i = '0;
    hold = '0;
    #12;
    chk("reset_busy", busy_o, 1'b0);
    chk("reset_done", done_o, 1'b0);
    chk("reset_result", result_o, 32'h0);
    chk("reset_state", state_o, ST_IDLE);
    rst_n = 1'b1;

    // Directed vectors; first start lands on the first edge after release.
    do_op(F3_MUL,    32'd7,        32'd6,        1, 32'h0000_002A);
    do_op(F3_MULH,   32'hFFFFFFFF, 32'h2,        1, 32'hFFFF_FFFF);
    do_op(F3_MULHU,  32'hFFFFFFFF, 32'h2,        1, 32'h0000_0001);
    do_op(F3_MULHSU, 32'hFFFFFFFF, 32'h2,        1, 32'hFFFF_FFFF);
    do_op(F3_DIV,    32'hFFFFFFF9, 32'h2,        1, 32'hFFFF_FFFD);
    do_op(F3_REM,    32'hFFFFFFF9, 32'h2,        1, 32'hFFFF_FFFF);
    do_op(F3_DIVU,   32'd100,      32'd0,        1, 32'hFFFF_FFFF);
    do_op(F3_REMU,   32'd100,      32'd0,        1, 32'h0000_0064);
    do_op(F3_DIV,    MIN,          ONES,         1, 32'h8000_0000);
    do_op(F3_REM,    MIN,          ONES,         1, 32'h0000_0000);

    // Flush and start together in IDLE: flush wins.
    funct3_i = F3_MUL; op_a_i = 32'd9; op_b_i = 32'd9;
    start_i = 1'b1; flush_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b0;
    chk("flush_beats_start", busy_o, 1'b0);

    // Flush ten cycles into a DIV: no done pulse, result untouched.
    funct3_i = F3_DIV; op_a_i = 32'd1000; op_b_i = 32'd7; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("busy_before_flush", busy_o, 1'b1);
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk("flush_busy", busy_o, 1'b0);
    chk("flush_done", done_o, 1'b0);
    chk("flush_result", result_o, 32'h0);
    repeat (40) @(posedge clk);
    #1;
    do_op(F3_MUL, 32'd3, 32'd5, 1, 32'h0000_000F);

    // Asynchronous reset five cycles into a MULHU.
    funct3_i = F3_MULHU; op_a_i = ONES; op_b_i = ONES; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_busy", busy_o, 1'b0);
    chk("async_reset_done", done_o, 1'b0);
    chk("async_reset_result", result_o, 32'h0);
    chk("async_reset_state", state_o, ST_IDLE);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    do_op(F3_MULHU, ONES, ONES, 1, 32'hFFFF_FFFE);

    // Randomized operations with biased corner operands.
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: begin a = MIN; b = ONES; end
        2: begin a = $urandom_range(0, 255); b = $urandom_range(1, 15); end
        3: begin a = {$urandom_range(0, 1) ? 1'b1 : 1'b0, 31'($urandom)}; b = ONES; end
        default: ;
      endcase
      do_op(f, a, b, 0, 32'h0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
